bus_control_sequencer: RTL and testbench

- Hardwired control unit for the single-bus CPU datapath.
- Steps the fetch / decode / execute T-states and drives every datapath strobe: register out/in enables, MARin, MDRin, IRin, Yin, ZLowIn/ZHighIn, IncPC, Read and the ALU operation code.
- Handles register-register ALU instructions, including two-result MUL/DIV via HI/LO.
- Stalls fetch on a memory-ready handshake.
- Sits beside the datapath top: takes the IR contents back and feeds strobes forward.

---
 rtl/bus_control_sequencer_pkg.sv | 67 ++++++
 rtl/bus_control_sequencer_if.sv | 30 +++
 rtl/bus_control_sequencer_opcode_class_decode.sv | 21 ++
 rtl/bus_control_sequencer.sv | 159 +++++++++++++++
 tb/tb_bus_control_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_control_sequencer_pkg.sv
// Shared opcode constants, state encoding and IR field layout for the single-bus
// CPU control unit; the ALU decodes the same opcode constants.
package bus_control_sequencer_pkg;

    localparam int IR_W       = 32;
    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
    } state_t;

    typedef struct packed {
        logic single_result;
        logic two_result;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

    // Every 1-bit control output, bundled so decode and checking work on one vector.
    typedef struct packed {
        logic PCout;
        logic ZLowout;
        logic ZHighout;
        logic MDRout;
        logic MARin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic PCin;
        logic ZLowIn;
        logic ZHighIn;
        logic HIin;
        logic LOin;
        logic IncPC;
        logic Read;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
        logic run;
        logic instr_done;
        logic fault;
    } strobes_t;

endpackage

// File: rtl/bus_control_sequencer_if.sv
// Sequencer <-> datapath signal bundle: IR/handshake back, strobes forward.
interface bus_control_sequencer_if #(
    parameter int OPCODE_W = 5
);
    logic [31:0]         IR;
    logic                mem_ready;
    logic                stop;
    logic                PCout, ZLowout, ZHighout, MDRout;
    logic                MARin, MDRin, IRin, Yin, PCin, ZLowIn, ZHighIn, HIin, LOin;
    logic                IncPC, Read;
    logic                Gra, Grb, Grc, Rin, Rout;
    logic [OPCODE_W-1:0] operation;
    logic                run, instr_done, fault;

    modport master (
        input  IR, mem_ready, stop,
        output PCout, ZLowout, ZHighout, MDRout,
        output MARin, MDRin, IRin, Yin, PCin, ZLowIn, ZHighIn, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output operation, run, instr_done, fault
    );

    modport slave (
        output IR, mem_ready, stop,
        input  PCout, ZLowout, ZHighout, MDRout,
        input  MARin, MDRin, IRin, Yin, PCin, ZLowIn, ZHighIn, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  operation, run, instr_done, fault
    );
endinterface

// File: rtl/bus_control_sequencer_opcode_class_decode.sv
// Combinational opcode classifier: which execute path an instruction takes.
module opcode_class_decode
    import bus_control_sequencer_pkg::*;
(
    input  logic [4:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: o_class.single_result = 1'b1;
            OP_MUL, OP_DIV:                 o_class.two_result    = 1'b1;
            OP_NOP:                         o_class.nop           = 1'b1;
            OP_HALT:                        o_class.halt          = 1'b1;
            default:                        o_class.illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_control_sequencer.sv
// Hardwired T-state control unit for the single-bus datapath.
// ILLEGAL_OP_TRAP_EN: undecoded opcodes fault in T3 instead of running as NOP.
module bus_control_sequencer
    import bus_control_sequencer_pkg::*;
#(
    parameter int OPCODE_W      = 5,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    bus_control_sequencer_if.master  bus
);

`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam bit TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    localparam int CNT_W      = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);

    state_t              r_state;
    logic [4:0]          r_opcode;
    logic [CNT_W-1:0]    r_wait;

    logic [4:0]          w_dec_op;
    op_class_t           w_cls;
    state_t              w_boundary;
    strobes_t            w_st;
    logic [OPCODE_W-1:0] w_op;

    // IR is only trustworthy from T3 on; later states use the copy latched there.
    assign w_dec_op   = (r_state == S_T3) ? bus.IR[IR_OPC_MSB:IR_OPC_LSB] : r_opcode;
    assign w_boundary = bus.stop ? S_HALT : S_T0;

    opcode_class_decode u_dec (
        .i_opcode (w_dec_op),
        .o_class  (w_cls)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_RST;
            r_opcode <= '0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                S_RST: r_state <= S_T0;
                S_T0: begin
                    r_wait  <= '0;
                    r_state <= S_T1;
                end
                S_T1: begin
                    if (bus.mem_ready)
                        r_state <= S_T2;
                    else if (TIMEOUT_EN && r_wait == CNT_W'(FETCH_TIMEOUT - 1))
                        r_state <= S_FAULT;
                    else
                        r_wait <= r_wait + CNT_W'(1);
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    r_opcode <= w_dec_op;
                    if (w_cls.halt)
                        r_state <= S_HALT;
                    else if (w_cls.nop || (w_cls.illegal && !TRAP_EN))
                        r_state <= w_boundary;
                    else if (w_cls.single_result || w_cls.two_result)
                        r_state <= S_T4;
                    else
                        r_state <= S_FAULT;
                end
                S_T4: r_state <= S_T5;
                S_T5: r_state <= w_cls.two_result ? S_T6 : w_boundary;
                S_T6: r_state <= w_boundary;
                S_HALT, S_FAULT: r_state <= r_state;
                default: r_state <= S_RST;
            endcase
        end
    end

    // Moore decode; RST/HALT fall through to all-zero.
    always_comb begin
        w_st = '0;
        w_op = '0;
        case (r_state)
            S_T0: begin
                w_st.PCout = 1'b1;
                w_st.MARin = 1'b1;
                w_st.IncPC = 1'b1;
            end
            S_T1: begin
                w_st.Read  = 1'b1;
                w_st.MDRin = 1'b1;
            end
            S_T2: begin
                w_st.MDRout = 1'b1;
                w_st.IRin   = 1'b1;
            end
            S_T3: begin
                w_st.Grb        = 1'b1;
                w_st.Rout       = 1'b1;
                w_st.Yin        = 1'b1;
                w_st.instr_done = w_cls.nop || (w_cls.illegal && !TRAP_EN);
            end
            S_T4: begin
                w_st.Grc     = 1'b1;
                w_st.Rout    = 1'b1;
                w_st.ZLowIn  = 1'b1;
                w_st.ZHighIn = w_cls.two_result;
                w_op         = OPCODE_W'(r_opcode);
            end
            S_T5: begin
                w_st.ZLowout = 1'b1;
                if (w_cls.two_result) begin
                    w_st.LOin = 1'b1;
                end else begin
                    w_st.Gra        = 1'b1;
                    w_st.Rin        = 1'b1;
                    w_st.instr_done = 1'b1;
                end
            end
            S_T6: begin
                w_st.ZHighout   = 1'b1;
                w_st.HIin       = 1'b1;
                w_st.instr_done = 1'b1;
            end
            S_FAULT: w_st.fault = 1'b1;
            default: ;
        endcase
        w_st.run = (r_state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6});
    end

    assign bus.PCout      = w_st.PCout;
    assign bus.ZLowout    = w_st.ZLowout;
    assign bus.ZHighout   = w_st.ZHighout;
    assign bus.MDRout     = w_st.MDRout;
    assign bus.MARin      = w_st.MARin;
    assign bus.MDRin      = w_st.MDRin;
    assign bus.IRin       = w_st.IRin;
    assign bus.Yin        = w_st.Yin;
    assign bus.PCin       = w_st.PCin;
    assign bus.ZLowIn     = w_st.ZLowIn;
    assign bus.ZHighIn    = w_st.ZHighIn;
    assign bus.HIin       = w_st.HIin;
    assign bus.LOin       = w_st.LOin;
    assign bus.IncPC      = w_st.IncPC;
    assign bus.Read       = w_st.Read;
    assign bus.Gra        = w_st.Gra;
    assign bus.Grb        = w_st.Grb;
    assign bus.Grc        = w_st.Grc;
    assign bus.Rin        = w_st.Rin;
    assign bus.Rout       = w_st.Rout;
    assign bus.run        = w_st.run;
    assign bus.instr_done = w_st.instr_done;
    assign bus.fault      = w_st.fault;
    assign bus.operation  = w_op;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Directed vector bench for bus_control_sequencer; the illegal-opcode rows
// follow ILLEGAL_OP_TRAP_EN when it is defined for the build.
module tb_bus_control_sequencer;
    import bus_control_sequencer_pkg::*;

    localparam strobes_t E_RST  = '0;
    localparam strobes_t E_T0   = '{PCout: 1'b1, MARin: 1'b1, IncPC: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T1   = '{Read: 1'b1, MDRin: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T2   = '{MDRout: 1'b1, IRin: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T3   = '{Grb: 1'b1, Rout: 1'b1, Yin: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_NOP3 = '{Grb: 1'b1, Rout: 1'b1, Yin: 1'b1, run: 1'b1, instr_done: 1'b1, default: 1'b0};
    localparam strobes_t E_T4   = '{Grc: 1'b1, Rout: 1'b1, ZLowIn: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T4M  = '{Grc: 1'b1, Rout: 1'b1, ZLowIn: 1'b1, ZHighIn: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T5   = '{ZLowout: 1'b1, Gra: 1'b1, Rin: 1'b1, instr_done: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T5M  = '{ZLowout: 1'b1, LOin: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_T6   = '{ZHighout: 1'b1, HIin: 1'b1, instr_done: 1'b1, run: 1'b1, default: 1'b0};
    localparam strobes_t E_FLT  = '{fault: 1'b1, default: 1'b0};

    typedef struct {
        logic        clr;
        logic        mr;
        logic        stop;
        logic [31:0] ir;
        strobes_t    exp;
        logic [4:0]  op;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir_next = '0;
    strobes_t    got;
    vec_t        tbl[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    bus_control_sequencer_if #(.OPCODE_W(5)) bus ();

    bus_control_sequencer #(.OPCODE_W(5), .FETCH_TIMEOUT(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Datapath IR register: loads the next instruction word when IRin is strobed.
    always @(posedge clk) begin
        if (clr)
            bus.IR <= '0;
        else if (bus.IRin)
            bus.IR <= ir_next;
    end

    always_comb begin
        got            = '0;
        got.PCout      = bus.PCout;
        got.ZLowout    = bus.ZLowout;
        got.ZHighout   = bus.ZHighout;
        got.MDRout     = bus.MDRout;
        got.MARin      = bus.MARin;
        got.MDRin      = bus.MDRin;
        got.IRin       = bus.IRin;
        got.Yin        = bus.Yin;
        got.PCin       = bus.PCin;
        got.ZLowIn     = bus.ZLowIn;
        got.ZHighIn    = bus.ZHighIn;
        got.HIin       = bus.HIin;
        got.LOin       = bus.LOin;
        got.IncPC      = bus.IncPC;
        got.Read       = bus.Read;
        got.Gra        = bus.Gra;
        got.Grb        = bus.Grb;
        got.Grc        = bus.Grc;
        got.Rin        = bus.Rin;
        got.Rout       = bus.Rout;
        got.run        = bus.run;
        got.instr_done = bus.instr_done;
        got.fault      = bus.fault;
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        logic [31:0] w;
        w = '0;
        w[IR_OPC_MSB:IR_OPC_LSB] = op;
        w[IR_RA_MSB:IR_RA_LSB]   = ra;
        w[IR_RB_MSB:IR_RB_LSB]   = rb;
        w[IR_RC_MSB:IR_RC_LSB]   = rc;
        return w;
    endfunction

    function automatic void add(input logic c, input logic m, input logic s,
                                input logic [31:0] ir, input strobes_t e,
                                input logic [4:0] op = 5'd0);
        vec_t v;
        v.clr = c; v.mr = m; v.stop = s; v.ir = ir; v.exp = e; v.op = op;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input strobes_t exp, input logic [4:0] eop);
        total++;
        if (got !== exp || bus.operation !== eop) begin
            bad++;
            $display("FAIL %s: got strobes=%h op=%b, want strobes=%h op=%b",
                     name, got, bus.operation, exp, eop);
        end
    endtask

    // Outputs are checked on the falling edge; inputs set there steer the next rising edge.
    task automatic cyc(input string name, input logic c, input logic m,
                       input strobes_t e, input logic [4:0] op = 5'd0);
        @(negedge clk);
        clr = c;
        bus.mem_ready = m;
        check(name, e, op);
    endtask

    initial begin
        logic [31:0] i_add, i_mul, i_div, i_sub, i_nop, i_hlt, i_ill;
        i_add = 32'h1A92_0000;
        i_mul = mk(OP_MUL, 4'd1, 4'd2, 4'd3);
        i_div = mk(OP_DIV, 4'd6, 4'd7, 4'd8);
        i_sub = mk(OP_SUB, 4'd9, 4'd10, 4'd11);
        i_nop = mk(OP_NOP, 4'd0, 4'd0, 4'd0);
        i_hlt = mk(OP_HALT, 4'd0, 4'd0, 4'd0);
        i_ill = mk(5'b11111, 4'd3, 4'd4, 4'd5);

        // ADD R5,R2,R4
        add(0, 1, 0, i_add, E_RST);
        add(0, 1, 0, i_add, E_T0);
        add(0, 1, 0, i_add, E_T1);
        add(0, 1, 0, i_add, E_T2);
        add(0, 1, 0, i_add, E_T3);
        add(0, 1, 0, i_add, E_T4, OP_ADD);
        add(0, 1, 0, i_add, E_T5);
        // MUL: two-result path
        add(0, 1, 0, i_mul, E_T0);
        add(0, 1, 0, i_mul, E_T1);
        add(0, 1, 0, i_mul, E_T2);
        add(0, 1, 0, i_mul, E_T3);
        add(0, 1, 0, i_mul, E_T4M, OP_MUL);
        add(0, 1, 0, i_mul, E_T5M);
        add(0, 1, 0, i_mul, E_T6);
        // NOP fetched with three wait states
        add(0, 1, 0, i_nop, E_T0);
        add(0, 0, 0, i_nop, E_T1);
        add(0, 0, 0, i_nop, E_T1);
        add(0, 0, 0, i_nop, E_T1);
        add(0, 1, 0, i_nop, E_T1);
        add(0, 1, 0, i_nop, E_T2);
        add(0, 1, 0, i_nop, E_NOP3);
        // DIV
        add(0, 1, 0, i_div, E_T0);
        add(0, 1, 0, i_div, E_T1);
        add(0, 1, 0, i_div, E_T2);
        add(0, 1, 0, i_div, E_T3);
        add(0, 1, 0, i_div, E_T4M, OP_DIV);
        add(0, 1, 0, i_div, E_T5M);
        add(0, 1, 0, i_div, E_T6);
        // SUB with stop raised in T5: completes, then halts until clr
        add(0, 1, 0, i_sub, E_T0);
        add(0, 1, 0, i_sub, E_T1);
        add(0, 1, 0, i_sub, E_T2);
        add(0, 1, 0, i_sub, E_T3);
        add(0, 1, 0, i_sub, E_T4, OP_SUB);
        add(0, 1, 1, i_sub, E_T5);
        add(0, 1, 0, i_sub, E_RST);
        add(0, 1, 0, i_sub, E_RST);
        add(1, 1, 0, i_sub, E_RST);
        add(0, 1, 0, i_hlt, E_RST);
        // HALT opcode: run drops after T3, PC never driven again
        add(0, 1, 0, i_hlt, E_T0);
        add(0, 1, 0, i_hlt, E_T1);
        add(0, 1, 0, i_hlt, E_T2);
        add(0, 1, 0, i_hlt, E_T3);
        add(0, 1, 0, i_hlt, E_RST);
        add(0, 1, 0, i_hlt, E_RST);
        add(1, 1, 0, i_hlt, E_RST);
        add(0, 1, 0, i_ill, E_RST);
        // Undecoded opcode 5'b11111
        add(0, 1, 0, i_ill, E_T0);
        add(0, 1, 0, i_ill, E_T1);
        add(0, 1, 0, i_ill, E_T2);
`ifdef ILLEGAL_OP_TRAP_EN
        add(0, 1, 0, i_ill, E_T3);
        add(0, 1, 0, i_ill, E_FLT);
        add(1, 1, 0, i_ill, E_FLT);
        add(0, 1, 0, i_ill, E_RST);
        add(0, 1, 0, i_ill, E_T0);
`else
        add(0, 1, 0, i_ill, E_NOP3);
        add(0, 1, 0, i_ill, E_T0);
        add(0, 1, 0, i_ill, E_T1);
`endif

        bus.mem_ready = 1'b1;
        bus.stop      = 1'b0;
        clr           = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            clr           = tbl[i].clr;
            bus.mem_ready = tbl[i].mr;
            bus.stop      = tbl[i].stop;
            ir_next       = tbl[i].ir;
            check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].op);
        end

        // Fetch timeout: 16 T1 cycles with no mem_ready, then sticky FAULT.
        @(negedge clk);
        clr = 1'b1;
        bus.stop = 1'b0;
        bus.mem_ready = 1'b0;
        cyc("to_rst", 0, 0, E_RST);
        cyc("to_t0", 0, 0, E_T0);
        for (int k = 0; k < 16; k++) cyc($sformatf("to_t1_%0d", k), 0, 0, E_T1);
        cyc("to_fault", 0, 1, E_FLT);
        for (int k = 0; k < 3; k++) cyc($sformatf("to_hold_%0d", k), 0, 1, E_FLT);
        cyc("to_clr", 1, 1, E_FLT);
        cyc("to_cleared", 0, 1, E_RST);

        // clr in T4 of an ADD aborts it: RST next, fresh fetch after.
        ir_next = i_add;
        cyc("ab_t0", 0, 1, E_T0);
        cyc("ab_t1", 0, 1, E_T1);
        cyc("ab_t2", 0, 1, E_T2);
        cyc("ab_t3", 0, 1, E_T3);
        cyc("ab_t4", 1, 1, E_T4, OP_ADD);
        cyc("ab_rst", 0, 1, E_RST);
        cyc("ab_refetch", 0, 1, E_T0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
